ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_if.sv | 24 ++
 rtl/ram_arbiter_rd_tag_pipe.sv | 39 +++
 rtl/ram_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and widths for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus: request/lock/write controls in, grant and read return out.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic [NREQ-1:0]             req;
    logic [NREQ-1:0]             lock;
    logic [NREQ-1:0]             we;
    logic [NREQ-1:0][ADDR_W-1:0] addr;
    logic [NREQ-1:0][DATA_W-1:0] wdata;
    logic [NREQ-1:0]             gnt;
    logic [NREQ-1:0]             rvalid;
    logic [NREQ-1:0][DATA_W-1:0] rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/ram_arbiter_rd_tag_pipe.sv
// Delay line of {valid, requester id} matching the RAM read latency.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic            push_id,
    output logic [NREQ-1:0] rvalid
);

    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] tag;

    // Shift read tags one stage per clock; reset drops everything in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld <= '0;
            tag <= '0;
        end else begin
            vld[0] <= push;
            tag[0] <= push_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    // Decode the final stage; held low while reset is asserted.
    always_comb begin
        rvalid    = '0;
        rvalid[0] = reset_n & vld[RD_LAT-1] & ~tag[RD_LAT-1];
        rvalid[1] = reset_n & vld[RD_LAT-1] &  tag[RD_LAT-1];
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: round-robin, lockable ownership with timeout.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_LAT   = 2,
    parameter int LOCK_MAX = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    ram_arbiter_if.slave      bus,
    output logic [ADDR_W-1:0] address_ram,
    output logic [DATA_W-1:0] data_ram,
    output logic              wren_ram,
    input  logic [DATA_W-1:0] q_ram,
    output logic              lock_err
);

    localparam int CNT_W = ($clog2(LOCK_MAX) + 1 > 5) ? $clog2(LOCK_MAX) + 1 : 5;
    // Grant cycle in IDLE counts as the first held cycle, so the last owned
    // cycle is reached when the counter shows LOCK_MAX-2.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 2);

    arb_state_t             state;
    logic                   last_gnt;
    logic [CNT_W-1:0]       lock_cnt;
    logic [NREQ-1:0]        gnt;
    logic                   gid;
    logic                   own_id;
    logic                   push;
    logic [NREQ-1:0]        rvalid;
    logic [NREQ-1:0][DATA_W-1:0] rdata;

    // Grant selection from current state and requests.
    always_comb begin
        gnt = '0;
        if (reset_n) begin
            case (state)
                IDLE:    gnt = (bus.req == 2'b11) ? (last_gnt ? 2'b01 : 2'b10) : bus.req;
                OWN0:    gnt[0] = bus.req[0];
                OWN1:    gnt[1] = bus.req[1];
                default: gnt = '0;
            endcase
        end
    end

    // RAM-side mux of the granted requester.
    always_comb begin
        gid         = gnt[1];
        own_id      = (state == OWN1);
        address_ram = '0;
        data_ram    = '0;
        wren_ram    = 1'b0;
        if (|gnt) begin
            address_ram = bus.addr[gid];
            data_ram    = bus.wdata[gid];
            wren_ram    = bus.we[gid];
        end
        push = (|gnt) & ~bus.we[gid];
    end

    // FSM, round-robin pointer, lock counter and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            lock_cnt <= '0;
            lock_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        last_gnt <= gid;
                        if (bus.lock[gid]) begin
                            state    <= gid ? OWN1 : OWN0;
                            lock_cnt <= '0;
                        end
                    end
                end
                OWN0, OWN1: begin
                    last_gnt <= own_id;
                    if (!bus.lock[own_id]) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        state    <= IDLE;
                        lock_cnt <= '0;
                        lock_err <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .push_id (gid),
        .rvalid  (rvalid)
    );

    // Return RAM data only to the requester whose read completes.
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rdata[i] = rvalid[i] ? q_ram : '0;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rdata;

endmodule
